// File: rtl/pyon_pkg.sv
// Shared types and helpers for the race scorer.
// Optional feature macro: PYON_PENALTY_EN adds the lane lockout state.
package pyon_pkg;

  typedef enum logic [1:0] {GIdle, GPlay, GEnd} game_state_e;

  typedef enum logic [2:0] {
    LArm,
    LIdle,
    LHeldL,
    LHeldR,
    LVoid
`ifdef PYON_PENALTY_EN
    , LLock
`endif
  } lane_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned MaxDigits = 8;
  typedef logic [4*MaxDigits-1:0] bcd_wide_t;

  // Increment the low `digits` BCD digits; an all-nines value is held.
  function automatic bcd_wide_t bcd_inc(input bcd_wide_t value, input int unsigned digits);
    bcd_wide_t  result;
    bcd_digit_t d;
    logic       carry;
    result = value;
    carry  = 1'b1;
    for (int unsigned i = 0; i < MaxDigits; i++) begin
      if (carry && (i < digits)) begin
        d = value[4*i +: 4];
        if (d == 4'd9) begin
          result[4*i +: 4] = 4'd0;
        end else begin
          result[4*i +: 4] = d + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    if (carry) result = value;
    return result;
  endfunction

endpackage

// File: rtl/pyon_lane.sv
// One player lane: press detection, side check, BCD score and binary count.
// Optional feature macro: PYON_PENALTY_EN adds a lockout after wrong presses.
module pyon_lane
  import pyon_pkg::*;
#(
  parameter int unsigned DIGITS       = 2,
  parameter int unsigned TARGET_BOXES = 20
`ifdef PYON_PENALTY_EN
  , parameter int unsigned PENALTY_CYCLES = 25
`endif
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                active_i,
  input  logic                key_l_i,
  input  logic                key_r_i,
  input  logic                next_side_i,
  output logic                step_o,
  output logic [DIGITS*4-1:0] score_o,
  output logic                at_target_o,
  output logic                locked_o
);

  localparam int unsigned CntW = $clog2(TARGET_BOXES + 1);

  lane_state_e         state_q, state_d;
  logic                step_q, step_d;
  logic [DIGITS*4-1:0] score_q, score_d;
  logic [CntW-1:0]     count_q, count_d;
  bcd_wide_t           score_wide, score_inc;
  logic                hit, miss;

`ifdef PYON_PENALTY_EN
  localparam int unsigned LockW = (PENALTY_CYCLES > 1) ? $clog2(PENALTY_CYCLES) : 1;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
`endif

  // Widen the score for the shared BCD helper
  always_comb begin
    score_wide               = '0;
    score_wide[DIGITS*4-1:0] = score_q;
    score_inc                = bcd_inc(score_wide, DIGITS);
  end

  if (DIGITS < MaxDigits) begin : g_unused_hi
    logic unused_inc_hi;
    assign unused_inc_hi = ^score_inc[4*MaxDigits-1:DIGITS*4];
  end

  // Lane FSM next state, score update and step generation
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    score_d = score_q;
    count_d = count_q;
    hit     = 1'b0;
    miss    = 1'b0;
`ifdef PYON_PENALTY_EN
    lock_cnt_d = lock_cnt_q;
`endif
    if (clear_i) begin
      state_d = LArm;
      score_d = '0;
      count_d = '0;
`ifdef PYON_PENALTY_EN
      lock_cnt_d = '0;
`endif
    end else if (!active_i) begin
      // Outside play the lane is parked; any press in flight is dropped
      state_d = LArm;
`ifdef PYON_PENALTY_EN
      lock_cnt_d = '0;
`endif
    end else begin
      unique case (state_q)
        LArm: begin
          if (!key_l_i && !key_r_i) state_d = LIdle;
        end
        LIdle: begin
          if (key_l_i && key_r_i) state_d = LVoid;
          else if (key_l_i)       state_d = LHeldL;
          else if (key_r_i)       state_d = LHeldR;
        end
        LHeldL: begin
          if (key_r_i) begin
            state_d = LVoid;
          end else if (!key_l_i) begin
            hit  = !next_side_i;
            miss = next_side_i;
          end
        end
        LHeldR: begin
          if (key_l_i) begin
            state_d = LVoid;
          end else if (!key_r_i) begin
            hit  = next_side_i;
            miss = !next_side_i;
          end
        end
        LVoid: begin
          if (!key_l_i && !key_r_i) miss = 1'b1;
        end
`ifdef PYON_PENALTY_EN
        LLock: begin
          if (lock_cnt_q == '0) state_d = LArm;
          else                  lock_cnt_d = lock_cnt_q - 1'b1;
        end
`endif
        default: state_d = LArm;
      endcase

      if (hit) begin
        state_d = LIdle;
        if (count_q != CntW'(TARGET_BOXES)) begin
          count_d = count_q + 1'b1;
          score_d = score_inc[DIGITS*4-1:0];
          step_d  = 1'b1;
        end
      end
      if (miss) begin
`ifdef PYON_PENALTY_EN
        state_d    = LLock;
        lock_cnt_d = LockW'(PENALTY_CYCLES - 1);
`else
        state_d = LIdle;
`endif
      end
    end
  end

  // Lane state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= LArm;
      step_q  <= 1'b0;
      score_q <= '0;
      count_q <= '0;
`ifdef PYON_PENALTY_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      score_q <= score_d;
      count_q <= count_d;
`ifdef PYON_PENALTY_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign step_o  = step_q;
  assign score_o = score_q;
  // Look-ahead so the game ends in the same cycle the final step appears
  assign at_target_o = (count_d == CntW'(TARGET_BOXES));
`ifdef PYON_PENALTY_EN
  assign locked_o = (state_q == LLock);
`else
  assign locked_o = 1'b0;
`endif

endmodule

// File: rtl/pyon_race_scorer.sv
// N-player race scorer: game FSM, winner latch and per-player lanes.
// Optional feature macro: PYON_PENALTY_EN enables wrong-press lockout.
module pyon_race_scorer
  import pyon_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned TARGET_BOXES   = 20,
  parameter int unsigned PENALTY_CYCLES = 25
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_PLAYERS-1:0]          key_l,
  input  logic [NUM_PLAYERS-1:0]          key_r,
  input  logic [NUM_PLAYERS-1:0]          next_side,
  output logic [NUM_PLAYERS-1:0]          step,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] score,
  output logic                            playing,
  output logic                            game_over,
  output logic [NUM_PLAYERS-1:0]          winner,
  output logic [NUM_PLAYERS-1:0]          locked
);

  if (DIGITS < 1 || DIGITS > MaxDigits) begin : g_bad_digits
    $error("DIGITS out of range");
  end
  if (TARGET_BOXES < 1 || TARGET_BOXES >= 10 ** DIGITS) begin : g_bad_target
    $error("TARGET_BOXES does not fit in DIGITS");
  end
  if (PENALTY_CYCLES < 1) begin : g_bad_penalty
    $error("PENALTY_CYCLES must be at least 1");
  end

  game_state_e            state_q, state_d;
  logic [NUM_PLAYERS-1:0] winner_q, winner_d;
  logic [NUM_PLAYERS-1:0] at_target;
  logic                   clear;
  logic                   active;

  // Game FSM: start edge clears, first lane at target ends the game
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    clear    = 1'b0;
    unique case (state_q)
      GIdle: begin
        if (start) begin
          state_d  = GPlay;
          clear    = 1'b1;
          winner_d = '0;
        end
      end
      GPlay: begin
        if (|at_target) begin
          state_d  = GEnd;
          winner_d = at_target;
        end else if (!start) begin
          state_d = GIdle;
        end
      end
      GEnd: begin
        // Requires start to drop before another game can begin
        if (!start) state_d = GIdle;
      end
      default: state_d = GIdle;
    endcase
  end

  // Game state and winner registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= GIdle;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  assign active    = (state_q == GPlay);
  assign playing   = (state_q == GPlay);
  assign game_over = (state_q == GEnd);
  assign winner    = winner_q;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    pyon_lane #(
      .DIGITS        (DIGITS),
      .TARGET_BOXES  (TARGET_BOXES)
`ifdef PYON_PENALTY_EN
      , .PENALTY_CYCLES(PENALTY_CYCLES)
`endif
    ) u_lane (
      .clk_i      (clk),
      .reset_i    (reset),
      .clear_i    (clear),
      .active_i   (active),
      .key_l_i    (key_l[p]),
      .key_r_i    (key_r[p]),
      .next_side_i(next_side[p]),
      .step_o     (step[p]),
      .score_o    (score[p*DIGITS*4 +: DIGITS*4]),
      .at_target_o(at_target[p]),
      .locked_o   (locked[p])
    );
  end

endmodule

// File: tb/tb_pyon_race_scorer.sv
// Self-checking bench for pyon_race_scorer (two players, two digits, target 20).
module tb_pyon_race_scorer;

  localparam int TGT = 20;
  localparam int PEN = 25;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  key_l, key_r, next_side;
  logic [1:0]  step, winner, locked;
  logic [15:0] score;
  logic        playing, game_over;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: correct-press count per player and game-ended flag
  int cnt[2];
  bit over;

  pyon_race_scorer #(
    .NUM_PLAYERS   (2),
    .DIGITS        (2),
    .TARGET_BOXES  (TGT),
    .PENALTY_CYCLES(PEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_l    (key_l),
    .key_r    (key_r),
    .next_side(next_side),
    .step     (step),
    .score    (score),
    .playing  (playing),
    .game_over(game_over),
    .winner   (winner),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] to_bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic logic [15:0] model_score();
    return {to_bcd(cnt[1]), to_bcd(cnt[0])};
  endfunction

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; key_l = '0; key_r = '0; next_side = '0;
    tick(); tick();
    reset = 1'b0;
    cnt[0] = 0; cnt[1] = 0; over = 1'b0;
  endtask

  // Start a game and let the lanes arm
  task automatic start_game();
    start = 1'b1;
    tick(); tick();
    cnt[0] = 0; cnt[1] = 0; over = 1'b0;
  endtask

  // Press masks (key_r joins one cycle late), release, then sample step twice
  task automatic gesture(input logic [1:0] lmask, input logic [1:0] rmask, input int hold,
                         output logic [1:0] s1, output logic [1:0] s2);
    key_l = lmask; key_r = '0;
    tick();
    key_r = rmask;
    repeat (hold) tick();
    key_l = '0; key_r = '0;
    tick(); s1 = step;
    tick(); s2 = step;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; next_side = '0;
    for (int i = 0; i < 2; i++) begin
      key_l = 2'($urandom); key_r = 2'($urandom);
      tick();
    end
    n_cmp++; if (step !== 2'b00) begin n_bad++; $display("FAIL reset_step got %b want 00", step); end
    n_cmp++; if (score !== 16'h0000) begin n_bad++; $display("FAIL reset_score got %h want 0000", score); end
    n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL reset_playing got %b want 0", playing); end
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL reset_over got %b want 0", game_over); end
    n_cmp++; if (winner !== 2'b00) begin n_bad++; $display("FAIL reset_winner got %b want 00", winner); end
    n_cmp++; if (locked !== 2'b00) begin n_bad++; $display("FAIL reset_locked got %b want 00", locked); end
    key_l = '0; key_r = '0;
    reset = 1'b0;
    tick();
    n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL idle_playing got %b want 0", playing); end
  endtask

  task automatic test_single_press();
    logic [1:0] s1, s2;
    do_reset();
    start_game();
    n_cmp++; if (playing !== 1'b1) begin n_bad++; $display("FAIL start_playing got %b want 1", playing); end
    next_side = 2'b00;
    gesture(2'b01, 2'b00, 2, s1, s2);
    cnt[0]++;
    n_cmp++; if (s1 !== 2'b01) begin n_bad++; $display("FAIL single_step got %b want 01", s1); end
    n_cmp++; if (s2 !== 2'b00) begin n_bad++; $display("FAIL single_step_width got %b want 00", s2); end
    n_cmp++; if (score[7:0] !== 8'h01) begin n_bad++; $display("FAIL single_score got %h want 01", score[7:0]); end
  endtask

  task automatic test_bcd_carry();
    logic [1:0] s1, s2;
    next_side = 2'b00;
    for (int i = 0; i < 8; i++) begin
      gesture(2'b01, 2'b00, 1, s1, s2);
      cnt[0]++;
    end
    n_cmp++; if (score[7:0] !== 8'h09) begin n_bad++; $display("FAIL carry_nine got %h want 09", score[7:0]); end
    gesture(2'b01, 2'b00, 1, s1, s2);
    cnt[0]++;
    n_cmp++; if (score[7:0] !== 8'h10) begin n_bad++; $display("FAIL carry_ten got %h want 10", score[7:0]); end
    n_cmp++; if (score !== model_score()) begin n_bad++; $display("FAIL carry_model got %h want %h", score, model_score()); end
  endtask

  task automatic test_wrong_press();
    logic [1:0] s1, s2;
    int c;
    next_side = 2'b00;
    key_r = 2'b01;
    tick(); tick();
    key_r = 2'b00;
    tick();
    n_cmp++; if (step !== 2'b00) begin n_bad++; $display("FAIL wrong_step got %b want 00", step); end
    n_cmp++; if (score[7:0] !== 8'h10) begin n_bad++; $display("FAIL wrong_score got %h want 10", score[7:0]); end
`ifdef PYON_PENALTY_EN
    c = 0;
    while (locked[0] === 1'b1 && c < 100) begin
      if (c == 3) key_l = 2'b01;
      if (c == 6) key_l = 2'b00;
      tick();
      c++;
    end
    n_cmp++; if (c != PEN) begin n_bad++; $display("FAIL lock_len got %0d want %0d", c, PEN); end
    tick();
    n_cmp++; if (score[7:0] !== 8'h10) begin n_bad++; $display("FAIL lock_ignored got %h want 10", score[7:0]); end
`else
    c = 0;
    for (int i = 0; i < 4; i++) begin
      if (locked !== 2'b00) c++;
      tick();
    end
    n_cmp++; if (c != 0) begin n_bad++; $display("FAIL locked_tied got %0d cycles locked want 0", c); end
`endif
    gesture(2'b01, 2'b00, 1, s1, s2);
    cnt[0]++;
    n_cmp++; if (s1 !== 2'b01) begin n_bad++; $display("FAIL after_wrong_step got %b want 01", s1); end
    n_cmp++; if (score[7:0] !== 8'h11) begin n_bad++; $display("FAIL after_wrong_score got %h want 11", score[7:0]); end
  endtask

  task automatic test_tie_end();
    logic [1:0] s1, s2;
    do_reset();
    start_game();
    next_side = 2'b00;
    for (int i = 0; i < TGT; i++) begin
      gesture(2'b11, 2'b00, 1, s1, s2);
      cnt[0]++; cnt[1]++;
      if (i == TGT - 1) begin
        n_cmp++; if (s1 !== 2'b11) begin n_bad++; $display("FAIL tie_final_step got %b want 11", s1); end
      end
    end
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL tie_over got %b want 1", game_over); end
    n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL tie_playing got %b want 0", playing); end
    n_cmp++; if (winner !== 2'b11) begin n_bad++; $display("FAIL tie_winner got %b want 11", winner); end
    n_cmp++; if (score !== 16'h2020) begin n_bad++; $display("FAIL tie_score got %h want 2020", score); end
    gesture(2'b11, 2'b00, 1, s1, s2);
    n_cmp++; if (s1 !== 2'b00) begin n_bad++; $display("FAIL post_end_step got %b want 00", s1); end
    n_cmp++; if (score !== 16'h2020) begin n_bad++; $display("FAIL post_end_score got %h want 2020", score); end
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL held_start_over got %b want 1", game_over); end
  endtask

  task automatic test_held_at_start();
    logic [1:0] s1, s2, seen;
    do_reset();
    next_side = 2'b00;
    key_l = 2'b01;
    start = 1'b1;
    seen  = '0;
    for (int i = 0; i < 3; i++) begin tick(); seen |= step; end
    key_l = 2'b00;
    tick(); seen |= step;
    tick(); seen |= step;
    n_cmp++; if (seen !== 2'b00) begin n_bad++; $display("FAIL held_no_step got %b want 00", seen); end
    n_cmp++; if (score !== 16'h0000) begin n_bad++; $display("FAIL held_score got %h want 0000", score); end
    gesture(2'b01, 2'b00, 1, s1, s2);
    n_cmp++; if (s1 !== 2'b01) begin n_bad++; $display("FAIL repress_step got %b want 01", s1); end
    n_cmp++; if (score[7:0] !== 8'h01) begin n_bad++; $display("FAIL repress_score got %h want 01", score[7:0]); end
    start = 1'b0;
    tick();
    n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL abort_playing got %b want 0", playing); end
    n_cmp++; if (score[7:0] !== 8'h01) begin n_bad++; $display("FAIL abort_hold got %h want 01", score[7:0]); end
    start = 1'b1;
    tick();
    n_cmp++; if (score !== 16'h0000) begin n_bad++; $display("FAIL restart_clear got %h want 0000", score); end
    n_cmp++; if (playing !== 1'b1) begin n_bad++; $display("FAIL restart_playing got %b want 1", playing); end
  endtask

  task automatic test_random();
    logic [1:0] s1, s2, lm, rm, exp_step, exp_win;
    int p, r, hold, c;
    bit correct, was_over;
    do_reset();
    start_game();
    exp_win = '0;
    for (int it = 0; it < 60; it++) begin
      p         = $urandom_range(0, 1);
      r         = $urandom_range(0, 9);
      hold      = $urandom_range(1, 3);
      next_side = 2'($urandom);
      lm = '0; rm = '0;
      if (r < 7) begin
        if (next_side[p]) rm[p] = 1'b1; else lm[p] = 1'b1;
      end else if (r < 9) begin
        if (next_side[p]) lm[p] = 1'b1; else rm[p] = 1'b1;
      end else begin
        lm[p] = 1'b1; rm[p] = 1'b1;
      end
      correct  = (r < 7);
      was_over = over;
      exp_step = '0;
      if (!over && correct) begin
        exp_step[p] = 1'b1;
        cnt[p]++;
        if (cnt[p] == TGT) begin over = 1'b1; exp_win[p] = 1'b1; end
      end
      gesture(lm, rm, hold, s1, s2);
      n_cmp++; if (s1 !== exp_step) begin n_bad++; $display("FAIL rnd_step it=%0d got %b want %b", it, s1, exp_step); end
      n_cmp++; if (s2 !== 2'b00) begin n_bad++; $display("FAIL rnd_step_width it=%0d got %b want 00", it, s2); end
      n_cmp++; if (score !== model_score()) begin n_bad++; $display("FAIL rnd_score it=%0d got %h want %h", it, score, model_score()); end
      n_cmp++; if (game_over !== over) begin n_bad++; $display("FAIL rnd_over it=%0d got %b want %b", it, game_over, over); end
`ifdef PYON_PENALTY_EN
      if (!was_over && !correct) begin
        c = 0;
        while (locked !== 2'b00 && c < 100) begin tick(); c++; end
        n_cmp++; if (c < 1 || c >= 100) begin n_bad++; $display("FAIL rnd_lock it=%0d got %0d cycles want 1..99", it, c); end
        tick();
      end
`else
      n_cmp++; if (locked !== 2'b00) begin n_bad++; $display("FAIL rnd_locked it=%0d got %b want 00", it, locked); end
      c = was_over ? 1 : 0;
`endif
    end
    if (over) begin
      n_cmp++; if (winner !== exp_win) begin n_bad++; $display("FAIL rnd_winner got %b want %b", winner, exp_win); end
    end else begin
      n_cmp++; if (winner !== 2'b00) begin n_bad++; $display("FAIL rnd_no_winner got %b want 00", winner); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_l = '0; key_r = '0; next_side = '0;
    test_reset();
    test_single_press();
    test_bcd_carry();
    test_wrong_press();
    test_tie_end();
    test_held_at_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
